weight_manager_spec: RTL and testbench
======================================

WEIGHT_MANAGER_SPEC -- requirements
Module: weight_manager

Interface
REQ-001 Parameter DEPTH, default 4096, entries per lane memory; cfg_ci_groups*cfg_co_groups SHALL NOT exceed DEPTH.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 write_mode  input  1  selects load phase; reads ignored while high.
REQ-005 data_valid  input  1  data_in carries one weight word this cycle.
REQ-006 data_in  input  72  weights of one (filter, channel): kernel position p (0..8) in bits [p*8+:8].
REQ-007 write_complete  output  1  all expected words stored.
REQ-008 cfg_ci_groups  input  10  input channels / 8.
REQ-009 cfg_co_groups  input  10  output filters / 8.
REQ-010 read_en  input  1  request next (og, ig) block.
REQ-011 data_ready  output  1  one-cycle pulse, data_out valid.
REQ-012 data_out  output  unpacked array [0:7] of 576  one word per filter offset 0..7.
REQ-013 read_complete  output  1  final block of sweep delivered.

Function
REQ-014 Storage: 8 banks (filter offset f%8) x 8 lanes (channel offset c%8), each DEPTH x 72 bits; address = og*cfg_ci_groups + ig.
REQ-015 Write order: filter-major, channel-minor (f=0..COUT-1 outer, c=0..CIN-1 inner); counters c_off, ig, f_off, og nest in that order, c_off fastest.
REQ-016 Write accepted only when write_mode=1, data_valid=1 and write_complete=0; stores data_in into bank f_off, lane c_off, address og*cfg_ci_groups+ig.
REQ-017 write_complete rises the cycle after the word with index 64*cfg_ci_groups*cfg_co_groups-1 is accepted; holds while write_mode=1; extra words ignored.
REQ-018 While write_mode=0, write counters and write_complete are held at 0.
REQ-019 Read: read_en sampled high with write_mode=0 fetches block at current read pointer (og, ig); pointer advances ig fastest, then og, wraps to (0,0) after last block.
REQ-020 data_out[k] bits [p*64 + j*8 +: 8] = weight(filter og*8+k, channel ig*8+j, position p), for p 0..8, j 0..7.
REQ-021 Latency: read_en sampled at edge N -> data_ready high for exactly one cycle after edge N+2; data_out holds until next data_ready.
REQ-022 read_en accepted every cycle; back-to-back requests yield back-to-back data_ready pulses in order.
REQ-023 read_complete asserts with data_ready of block (cfg_co_groups-1, cfg_ci_groups-1); held until next accepted read_en or write_mode=1.
REQ-024 write_mode rising resets read pointer to (0,0); read_en during write_mode ignored.
REQ-025 Config inputs SHALL be stable during a write or read sweep; behaviour otherwise undefined.

Reset
REQ-026 rst: write/read counters, pointer, pipeline valids zeroed; write_complete, data_ready, read_complete = 0; data_out = 0.
REQ-027 Memory contents not reset; rst mid-write/read aborts operation, in-flight data_ready suppressed.

Configuration
REQ-028 Macro WEIGHT_MANAGER_OUT_REG_EN: defined -> extra output register stage, data_ready after edge N+3; undefined -> N+2 per REQ-021; all other behaviour identical.

Verification
REQ-029 ci=8,co=16 groups: write 8192 words {f[7:0],c[7:0],56'h11223344556677} -> write_complete high within 1 cycle of last word.
REQ-030 Same load, 128 single read_en pulses -> every data_out[k] equals REQ-020 reconstruction; block (og=3,ig=5) byte p=8,j=2 of k=1 = 8'h19.
REQ-031 Final read (og=15,ig=7) -> read_complete with its data_ready; next read_en returns block (0,0) and clears read_complete.
REQ-032 Four consecutive read_en cycles -> four consecutive data_ready pulses at fixed latency, blocks (0,0)..(0,3).
REQ-033 rst asserted mid-write after 100 words -> outputs 0; reload full set with write_mode -> correct write_complete and read data.
REQ-034 Extra 5 words after write_complete and read_en during write_mode -> no memory change, no data_ready.

Source files
------------

// File: rtl/weight_manager_spec.sv
// Weight store: 8 banks x 8 lanes of DEPTH x 72-bit words, written filter-major, read one 8x8 block per request.
// Optional macro WEIGHT_MANAGER_OUT_REG_EN adds one output register stage (read latency 3 instead of 2).
module weight_manager_spec #(
   parameter int DEPTH = 4096
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           write_mode,
   input  logic           data_valid,
   input  logic [71:0]    data_in,
   output logic           write_complete,
   input  logic [9:0]     cfg_ci_groups,
   input  logic [9:0]     cfg_co_groups,
   input  logic           read_en,
   output logic           data_ready,
   output logic [575:0]   data_out [0:7],
   output logic           read_complete
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [71:0]  mem_q [0:7][0:7][0:DEPTH-1];

   logic [2:0]   wr_c_q, wr_c_d;
   logic [9:0]   wr_ig_q, wr_ig_d;
   logic [2:0]   wr_f_q, wr_f_d;
   logic [9:0]   wr_og_q, wr_og_d;
   logic         write_complete_q, write_complete_d;
   logic         wr_acc_s;
   logic [AW-1:0] wr_addr_s;

   logic [9:0]   rd_og_q, rd_og_d;
   logic [9:0]   rd_ig_q, rd_ig_d;
   logic         rd_acc_s;
   logic         ptr_last_s;
   logic [9:0]   ci_last_s, co_last_s;

   logic         s1_valid_q, s1_valid_d;
   logic         s1_last_q, s1_last_d;
   logic [AW-1:0] s1_addr_q, s1_addr_d;
   logic         s2_valid_q, s2_valid_d;
   logic         s2_last_q, s2_last_d;
   logic [71:0]  rd_word_q [0:7][0:7];
   logic [71:0]  rd_word_d [0:7][0:7];
   logic         s3_valid_q, s3_valid_d;
   logic         s3_last_q, s3_last_d;
   logic [575:0] s3_data_q [0:7];
   logic [575:0] s3_data_d [0:7];
   logic         read_complete_q, read_complete_d;

   logic         fin_valid_s;
   logic         fin_set_s;
   logic [575:0] fin_data_s [0:7];

   assign ci_last_s  = cfg_ci_groups - 10'd1;
   assign co_last_s  = cfg_co_groups - 10'd1;
   assign wr_acc_s   = write_mode & data_valid & ~write_complete_q;
   assign wr_addr_s  = AW'(wr_og_q) * AW'(cfg_ci_groups) + AW'(wr_ig_q);
   assign rd_acc_s   = read_en & ~write_mode;
   assign ptr_last_s = (rd_og_q == co_last_s) && (rd_ig_q == ci_last_s);

   // Write counters nest c_off -> ig -> f_off -> og; all held at zero outside load phase.
   always_comb begin
      wr_c_d           = wr_c_q;
      wr_ig_d          = wr_ig_q;
      wr_f_d           = wr_f_q;
      wr_og_d          = wr_og_q;
      write_complete_d = write_complete_q;
      if (!write_mode) begin
         wr_c_d           = 3'd0;
         wr_ig_d          = 10'd0;
         wr_f_d           = 3'd0;
         wr_og_d          = 10'd0;
         write_complete_d = 1'b0;
      end else if (wr_acc_s) begin
         wr_c_d = wr_c_q + 3'd1;
         if (wr_c_q == 3'd7) begin
            if (wr_ig_q == ci_last_s) begin
               wr_ig_d = 10'd0;
               wr_f_d  = wr_f_q + 3'd1;
               if (wr_f_q == 3'd7) begin
                  if (wr_og_q == co_last_s) begin
                     wr_og_d          = 10'd0;
                     write_complete_d = 1'b1;
                  end else begin
                     wr_og_d = wr_og_q + 10'd1;
                  end
               end else begin
                  wr_og_d = wr_og_q;
               end
            end else begin
               wr_ig_d = wr_ig_q + 10'd1;
            end
         end else begin
            wr_ig_d = wr_ig_q;
         end
      end else begin
         write_complete_d = write_complete_q;
      end
   end

   // Read pointer walks ig fastest then og; it sits at (0,0) throughout the load phase.
   always_comb begin
      rd_og_d = rd_og_q;
      rd_ig_d = rd_ig_q;
      if (write_mode) begin
         rd_og_d = 10'd0;
         rd_ig_d = 10'd0;
      end else if (rd_acc_s) begin
         if (rd_ig_q == ci_last_s) begin
            rd_ig_d = 10'd0;
            rd_og_d = (rd_og_q == co_last_s) ? 10'd0 : rd_og_q + 10'd1;
         end else begin
            rd_ig_d = rd_ig_q + 10'd1;
         end
      end else begin
         rd_og_d = rd_og_q;
      end
   end

   // Read pipeline: address -> registered RAM read -> byte reshuffle into data_out layout.
   always_comb begin
      s1_valid_d = rd_acc_s;
      s1_last_d  = rd_acc_s & ptr_last_s;
      s1_addr_d  = AW'(rd_og_q) * AW'(cfg_ci_groups) + AW'(rd_ig_q);
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;
      s3_data_d  = s3_data_q;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 8; j++) begin
            rd_word_d[k][j] = mem_q[k][j][s1_addr_q];
         end
      end
      if (s2_valid_q) begin
         for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < 9; p++) begin
               for (int j = 0; j < 8; j++) begin
                  s3_data_d[k][p*64 + j*8 +: 8] = rd_word_q[k][j][p*8 +: 8];
               end
            end
         end
      end else begin
         s3_data_d = s3_data_q;
      end
   end

`ifdef WEIGHT_MANAGER_OUT_REG_EN
   logic         s4_valid_q;
   logic         s4_last_q;
   logic [575:0] s4_data_q [0:7];
   logic [575:0] s4_data_d [0:7];

   // Extra output stage holds its data between pulses like the base stage.
   always_comb begin
      s4_data_d = s4_data_q;
      if (s3_valid_q) begin
         s4_data_d = s3_data_q;
      end else begin
         s4_data_d = s4_data_q;
      end
   end

   // Extra output stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s4_valid_q <= 1'b0;
         s4_last_q  <= 1'b0;
         s4_data_q  <= '{default: {576{1'b0}}};
      end else begin
         s4_valid_q <= s3_valid_q;
         s4_last_q  <= s3_last_q;
         s4_data_q  <= s4_data_d;
      end
   end

   assign fin_valid_s = s4_valid_q;
   assign fin_set_s   = s3_valid_q & s3_last_q;
   assign fin_data_s  = s4_data_q;
`else
   assign fin_valid_s = s3_valid_q;
   assign fin_set_s   = s2_valid_q & s2_last_q;
   assign fin_data_s  = s3_data_q;
`endif

   // read_complete rises together with the last block's data_ready; setting wins over a same-cycle clear.
   always_comb begin
      read_complete_d = read_complete_q;
      if (write_mode) begin
         read_complete_d = 1'b0;
      end else if (fin_set_s) begin
         read_complete_d = 1'b1;
      end else if (rd_acc_s) begin
         read_complete_d = 1'b0;
      end else begin
         read_complete_d = read_complete_q;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_c_q           <= 3'd0;
         wr_ig_q          <= 10'd0;
         wr_f_q           <= 3'd0;
         wr_og_q          <= 10'd0;
         write_complete_q <= 1'b0;
         rd_og_q          <= 10'd0;
         rd_ig_q          <= 10'd0;
         s1_valid_q       <= 1'b0;
         s1_last_q        <= 1'b0;
         s1_addr_q        <= {AW{1'b0}};
         s2_valid_q       <= 1'b0;
         s2_last_q        <= 1'b0;
         s3_valid_q       <= 1'b0;
         s3_last_q        <= 1'b0;
         s3_data_q        <= '{default: {576{1'b0}}};
         read_complete_q  <= 1'b0;
      end else begin
         wr_c_q           <= wr_c_d;
         wr_ig_q          <= wr_ig_d;
         wr_f_q           <= wr_f_d;
         wr_og_q          <= wr_og_d;
         write_complete_q <= write_complete_d;
         rd_og_q          <= rd_og_d;
         rd_ig_q          <= rd_ig_d;
         s1_valid_q       <= s1_valid_d;
         s1_last_q        <= s1_last_d;
         s1_addr_q        <= s1_addr_d;
         s2_valid_q       <= s2_valid_d;
         s2_last_q        <= s2_last_d;
         s3_valid_q       <= s3_valid_d;
         s3_last_q        <= s3_last_d;
         s3_data_q        <= s3_data_d;
         read_complete_q  <= read_complete_d;
      end
   end

   // Weight memory and its registered read port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_q[wr_f_q][wr_c_q][wr_addr_s] <= data_in;
      end
      rd_word_q <= rd_word_d;
   end

   assign write_complete = write_complete_q;
   assign data_ready     = fin_valid_s;
   assign data_out       = fin_data_s;
   assign read_complete  = read_complete_q;

endmodule

// File: tb/tb_weight_manager_spec.sv
// Directed bench for weight_manager_spec: full load, read sweep, burst reads, reset abort and reload.
module tb_weight_manager_spec;

`ifdef WEIGHT_MANAGER_OUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   localparam int CI = 8;
   localparam int CO = 16;
   localparam int NWORDS = 64 * CI * CO;

   logic         clk = 1'b0;
   logic         rst;
   logic         write_mode;
   logic         data_valid;
   logic [71:0]  data_in;
   logic         write_complete;
   logic [9:0]   cfg_ci_groups;
   logic [9:0]   cfg_co_groups;
   logic         read_en;
   logic         data_ready;
   logic [575:0] data_out [0:7];
   logic         read_complete;

   int vectors = 0;
   int miscompares = 0;
   logic [575:0] tmp;

   weight_manager_spec dut (
      .clk            (clk),
      .rst            (rst),
      .write_mode     (write_mode),
      .data_valid     (data_valid),
      .data_in        (data_in),
      .write_complete (write_complete),
      .cfg_ci_groups  (cfg_ci_groups),
      .cfg_co_groups  (cfg_co_groups),
      .read_en        (read_en),
      .data_ready     (data_ready),
      .data_out       (data_out),
      .read_complete  (read_complete)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] word_of(input int f, input int c);
      return {f[7:0], c[7:0], 56'h11223344556677};
   endfunction

   function automatic logic [575:0] exp_block(input int og, input int ig, input int k);
      logic [575:0] r;
      logic [71:0]  w;
      r = {576{1'b0}};
      for (int j = 0; j < 8; j++) begin
         w = word_of(og*8 + k, ig*8 + j);
         for (int p = 0; p < 9; p++) r[p*64 + j*8 +: 8] = w[p*8 +: 8];
      end
      return r;
   endfunction

   // Streams n words in filter-major order; garbage inverts the pattern.
   task automatic write_words(input int n, input logic garbage, input logic expect_done);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (expect_done && i == n-1) chk("wc_before_last", write_complete, 1'b0);
         write_mode = 1'b1;
         data_valid = 1'b1;
         data_in    = garbage ? ~word_of(i/64, i%64) : word_of(i/64, i%64);
      end
      @(negedge clk);
      data_valid = 1'b0;
      if (expect_done) chk("wc_after_last", write_complete, 1'b1);
   endtask

   // Single read pulse with exact latency, data, and read_complete checks.
   task automatic do_read(input int og, input int ig, input logic exp_rc);
      @(negedge clk);
      read_en = 1'b1;
      @(negedge clk);
      read_en = 1'b0;
      chk("rc_cleared", read_complete, 1'b0);
      chk("dr_early", data_ready, 1'b0);
      for (int m = 1; m <= LAT; m++) begin
         @(negedge clk);
         if (m < LAT) begin
            chk("dr_early", data_ready, 1'b0);
         end else begin
            chk("dr_pulse", data_ready, 1'b1);
            chk("rc_with_dr", read_complete, exp_rc);
            for (int k = 0; k < 8; k++) chk("rd_data", data_out[k], exp_block(og, ig, k));
         end
      end
      @(negedge clk);
      chk("dr_one_cycle", data_ready, 1'b0);
      chk("rc_hold", read_complete, exp_rc);
      chk("dout_hold", data_out[7], exp_block(og, ig, 7));
   endtask

   initial begin
      rst = 1'b1; write_mode = 1'b0; data_valid = 1'b0; data_in = 72'd0;
      read_en = 1'b0; cfg_ci_groups = 10'(CI); cfg_co_groups = 10'(CO);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wc", write_complete, 1'b0);
      chk("rst_dr", data_ready, 1'b0);
      chk("rst_rc", read_complete, 1'b0);
      for (int k = 0; k < 8; k++) chk("rst_dout", data_out[k], {576{1'b0}});

      // Full load, then extra words and read requests while still in load phase.
      write_words(NWORDS, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("dr_during_write", data_ready, 1'b0);
         data_valid = 1'b1;
         data_in    = ~word_of(i, i);
         read_en    = 1'b1;
      end
      @(negedge clk);
      data_valid = 1'b0;
      read_en    = 1'b0;
      chk("dr_during_write", data_ready, 1'b0);
      chk("wc_hold", write_complete, 1'b1);
      for (int i = 0; i < LAT + 1; i++) begin
         @(negedge clk);
         chk("dr_during_write", data_ready, 1'b0);
      end
      write_mode = 1'b0;
      @(negedge clk);
      chk("wc_cleared", write_complete, 1'b0);

      // Full sweep of single reads.
      for (int b = 0; b < CI*CO; b++) begin
         do_read(b / CI, b % CI, (b == CI*CO - 1) ? 1'b1 : 1'b0);
         if (b == 3*CI + 5) begin
            tmp = data_out[1];
            chk("byte_og3_ig5", tmp[8*64 + 2*8 +: 8], 8'h19);
         end
      end
      do_read(0, 0, 1'b0);

      // Pointer reset via write_mode, then four back-to-back requests.
      @(negedge clk);
      write_mode = 1'b1;
      @(negedge clk);
      write_mode = 1'b0;
      read_en    = 1'b1;
      for (int m = 0; m <= LAT + 4; m++) begin
         @(negedge clk);
         if (m == 3) read_en = 1'b0;
         chk("burst_dr", data_ready, (m >= LAT && m <= LAT + 3) ? 1'b1 : 1'b0);
         if (m >= LAT && m <= LAT + 3) begin
            chk("burst_d0", data_out[0], exp_block(0, m - LAT, 0));
            chk("burst_d7", data_out[7], exp_block(0, m - LAT, 7));
         end
      end

      // Reset while a read is in flight suppresses its data_ready.
      @(negedge clk);
      read_en = 1'b1;
      @(negedge clk);
      read_en = 1'b0;
      rst     = 1'b1;
      for (int m = 0; m < LAT + 2; m++) begin
         @(negedge clk);
         chk("rst_inflight_dr", data_ready, 1'b0);
      end
      chk("rst_inflight_dout", data_out[3], {576{1'b0}});
      rst = 1'b0;

      // Reset mid-write after 100 corrupt words, then a clean reload.
      write_words(100, 1'b1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_wc", write_complete, 1'b0);
      chk("rst_mid_dr", data_ready, 1'b0);
      chk("rst_mid_rc", read_complete, 1'b0);
      chk("rst_mid_dout", data_out[0], {576{1'b0}});
      rst        = 1'b0;
      write_mode = 1'b0;
      @(negedge clk);
      write_words(NWORDS, 1'b0, 1'b1);
      @(negedge clk);
      write_mode = 1'b0;
      for (int b = 0; b < 9; b++) do_read(b / CI, b % CI, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
